jtframe_mist_spi_loader: RTL
============================

// Module: jtframe_mist_spi_loader
// PURPOSE
// - SPI master that drives the MiST data_io file-transfer protocol from the MCU side: sends file index, start, data bytes and end frames.
// - Feeds the core's SPI_SCK/SPI_SS2/SPI_DI pins when no ARM controller is present (Neptuno-style boards, simulation benches).
// - Pulls payload bytes from a byte-wide source (BRAM, flash reader) through a request/ok handshake.
// PARAMETERS
// - AW      26  byte-address/length width (matches ioctl_addr)
// - CLKDIV   4  clk cycles per SCK half-period; legal >=2
// - GAP      8  clk cycles SS2 held high between frames
// PORTS
// - clk       in   1   system clock
// - rst_n     in   1   synchronous reset, active low
// - start     in   1   one-cycle pulse; begins transfer when idle
// - file_idx  in   8   file index sent in the index frame; sampled at start
// - len       in   AW  payload byte count; sampled at start; 0 = no data frame
// - src_addr  out  AW  byte address requested (0..len-1)
// - src_rd    out  1   request strobe, held until src_ok
// - src_ok    in   1   src_data valid; one-cycle pulse
// - src_data  in   8   payload byte
// - spi_sck   out  1   SPI clock, idle low (mode 0)
// - spi_ss2   out  1   data_io chip select, active low
// - spi_di    out  1   MOSI (core's SPI_DI)
// - busy      out  1   high from start accepted until DONE left
// - done      out  1   one-cycle pulse after end frame released
// - chksum    out  16  payload checksum (see CONFIGURATION)
// BEHAVIOUR
// - Reset: spi_sck=0, spi_ss2=1, spi_di=0, src_rd=0, src_addr=0, busy=0, done=0, chksum=0, FSM=IDLE.
// - Bit engine: MSB first; spi_di changes while SCK low, SCK rises after CLKDIV clk, falls after another CLKDIV; 8 bits = 16*CLKDIV clk.
// - Frame: SS2 falls, CLKDIV clk setup, bytes back-to-back, CLKDIV clk hold after last fall, SS2 rises, GAP clk high.
// - FSM: IDLE -> IDX{0x53,file_idx} -> START{0x54,0xFF} -> DATA{0x55,byte0..byte len-1} -> END{0x54,0x00} -> DONE -> IDLE.
// - len==0: DATA state skipped; START goes directly to END.
// - Prefetch: src_rd asserted for byte n+1 while byte n shifts; SCK stretched low (no edge) if src_ok has not arrived when next byte must load.
// - src_addr increments by 1 on each src_ok; never exceeds len-1; no request issued after last byte.
// - start ignored while busy; start on same cycle as DONE is ignored.
// - done pulses for exactly one clk on DONE->IDLE; busy falls same cycle.
// - rst_n low mid-transfer: all outputs return to reset values next clk; SS2 rises immediately, no partial byte completion.
// - len at max (2^AW-1) valid; internal counter AW bits wide, compares against len-1, no wrap.
// CONFIGURATION
// - JTFRAME_SPI_LOADER_CHKSUM_EN defined: chksum = 16-bit wrap-around sum of payload bytes, cleared on start, updated on each src_ok.
// - Not defined: chksum tied to 0, adder removed.
// TESTING
// - file_idx=0x01, len=4, bytes {11,22,33,44}, CLKDIV=2 -> MOSI decodes 53 01 | 54 FF | 55 11 22 33 44 | 54 00, four SS2 frames, done once.
// - len=0 -> frames 53 xx | 54 FF | 54 00 only; src_rd never asserted.
// - src_ok delayed 40 clk on byte 2 -> SCK held low during wait, no extra/missing edges, payload intact.
// - rst_n low during byte 1 of DATA -> next clk SS2=1, SCK=0, busy=0; new start runs full clean sequence.
// - start pulsed again while busy -> ignored; only one transfer observed.
// - CHKSUM_EN, bytes {FF,FF,02} -> chksum=0x0200; without macro chksum=0.

Source files
------------

// File: rtl/jtframe_mist_spi_loader.sv
// jtframe_mist_spi_loader
//
// SPI master that plays the MCU side of the MiST data_io file-transfer
// protocol. It drives the core's SPI_SCK / SPI_SS2 / SPI_DI pins, which is
// useful on boards with no ARM controller and in simulation benches.
//
// Sequence of SS2 frames for one transfer:
//   {0x53, file_idx}  {0x54, 0xFF}  {0x55, byte0 .. byte len-1}  {0x54, 0x00}
// The data frame is skipped when len == 0.
//
// Parameters
//   AW      byte-address / length width
//   CLKDIV  clk cycles per SCK half-period (>= 2)
//   GAP     clk cycles SS2 stays high between frames (>= 1)
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle pulse, accepted only when idle
//   file_idx, len       sampled when start is accepted
//   src_addr, src_rd    payload byte request, held until src_ok
//   src_ok, src_data    payload byte return (src_ok is a one-cycle pulse)
//   spi_sck/ss2/di      SPI mode 0 master outputs
//   busy, done          status; done pulses once as the FSM returns to idle
//   chksum              16-bit payload sum, only when
//                       JTFRAME_SPI_LOADER_CHKSUM_EN is defined, else 0

module jtframe_mist_spi_loader #(
    parameter int unsigned AW     = 26,
    parameter int unsigned CLKDIV = 4,
    parameter int unsigned GAP    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    file_idx,
    input  logic [AW-1:0] len,
    output logic [AW-1:0] src_addr,
    output logic          src_rd,
    input  logic          src_ok,
    input  logic [7:0]    src_data,
    output logic          spi_sck,
    output logic          spi_ss2,
    output logic          spi_di,
    output logic          busy,
    output logic          done,
    output logic [15:0]   chksum
);

    typedef enum logic [2:0] {StIdle, StIdx, StStart, StData, StEnd, StDone} state_t;
    typedef enum logic [2:0] {PhSetup, PhLow, PhHigh, PhLoad, PhHold, PhGap} phase_t;

    localparam logic [15:0] DIV_LAST = 16'(CLKDIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP - 1);

    state_t        st, nxt_st;
    phase_t        ph;
    logic [15:0]   cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    sh;
    logic          last_byte;     // byte in the shifter closes the frame
    logic [7:0]    file_q;
    logic [AW-1:0] len_m1;
    logic          len_zero;
    logic [7:0]    dbuf;          // prefetched payload byte
    logic          dvalid;
    logic          fetch_done;    // last payload byte already received
    logic [AW-1:0] load_idx;      // payload bytes moved into the shifter
    logic [7:0]    nxt_hdr;
    logic [7:0]    second;
    logic          src_take;

    assign src_take = src_rd & src_ok;

    always_comb begin
        nxt_st = StDone;
        case (st)
            StIdx:   nxt_st = StStart;
            StStart: nxt_st = len_zero ? StEnd : StData;
            StData:  nxt_st = StEnd;
            default: nxt_st = StDone;
        endcase
        nxt_hdr = (nxt_st == StData) ? 8'h55 : 8'h54;
        // Second byte of the fixed two-byte frames
        second  = (st == StIdx) ? file_q : (st == StStart) ? 8'hFF : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st         <= StIdle;
            ph         <= PhSetup;
            cnt        <= '0;
            bit_cnt    <= '0;
            sh         <= '0;
            last_byte  <= 1'b0;
            file_q     <= '0;
            len_m1     <= '0;
            len_zero   <= 1'b1;
            dbuf       <= '0;
            dvalid     <= 1'b0;
            fetch_done <= 1'b0;
            load_idx   <= '0;
            src_addr   <= '0;
            src_rd     <= 1'b0;
            spi_sck    <= 1'b0;
            spi_ss2    <= 1'b1;
            spi_di     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                StIdle: begin
                    if (start) begin
                        file_q     <= file_idx;
                        len_m1     <= len - AW'(1);
                        len_zero   <= (len == '0);
                        dvalid     <= 1'b0;
                        fetch_done <= 1'b0;
                        load_idx   <= '0;
                        src_addr   <= '0;
                        busy       <= 1'b1;
                        st         <= StIdx;
                        // open the index frame
                        spi_ss2    <= 1'b0;
                        ph         <= PhSetup;
                        cnt        <= '0;
                        bit_cnt    <= '0;
                        last_byte  <= 1'b0;
                        sh         <= 8'h53;
                        spi_di     <= 1'b0;
                    end
                end
                StDone: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    st   <= StIdle;
                end
                StIdx, StStart, StData, StEnd: begin
                    case (ph)
                        PhSetup: begin
                            if (cnt == DIV_LAST) begin
                                cnt <= '0;
                                ph  <= PhLow;
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                        PhLow: begin
                            if (cnt == DIV_LAST) begin
                                cnt     <= '0;
                                spi_sck <= 1'b1;
                                ph      <= PhHigh;
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                        PhHigh: begin
                            if (cnt == DIV_LAST) begin
                                cnt     <= '0;
                                spi_sck <= 1'b0;
                                if (bit_cnt != 3'd7) begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                    sh      <= {sh[6:0], 1'b0};
                                    spi_di  <= sh[6];
                                    ph      <= PhLow;
                                end else begin
                                    ph <= last_byte ? PhHold : PhLoad;
                                end
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                        // SCK is low here; the load cycle counts as the first
                        // low cycle, and SCK stays low while payload is late.
                        PhLoad: begin
                            if (st != StData) begin
                                sh        <= second;
                                spi_di    <= second[7];
                                last_byte <= 1'b1;
                                bit_cnt   <= '0;
                                cnt       <= 16'd1;
                                ph        <= PhLow;
                            end else if (dvalid) begin
                                sh        <= dbuf;
                                spi_di    <= dbuf[7];
                                dvalid    <= 1'b0;
                                last_byte <= (load_idx == len_m1);
                                load_idx  <= load_idx + AW'(1);
                                bit_cnt   <= '0;
                                cnt       <= 16'd1;
                                ph        <= PhLow;
                            end
                        end
                        PhHold: begin
                            if (cnt == DIV_LAST) begin
                                cnt     <= '0;
                                spi_ss2 <= 1'b1;
                                spi_di  <= 1'b0;
                                ph      <= PhGap;
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                        PhGap: begin
                            if (cnt == GAP_LAST) begin
                                cnt <= '0;
                                st  <= nxt_st;
                                if (nxt_st != StDone) begin
                                    spi_ss2   <= 1'b0;
                                    ph        <= PhSetup;
                                    bit_cnt   <= '0;
                                    last_byte <= 1'b0;
                                    sh        <= nxt_hdr;
                                    spi_di    <= nxt_hdr[7];
                                end
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                        default: ph <= PhGap;
                    endcase
                end
                default: st <= StIdle;
            endcase

            // Payload prefetch: one byte buffered ahead of the shifter.
            // A response can only arrive while dvalid is low, so it never
            // collides with the shifter draining dbuf above.
            if (src_take) begin
                dbuf   <= src_data;
                dvalid <= 1'b1;
                src_rd <= 1'b0;
                if (src_addr == len_m1) fetch_done <= 1'b1;
                else                    src_addr   <= src_addr + AW'(1);
            end else if (st == StData && !src_rd && !dvalid && !fetch_done) begin
                src_rd <= 1'b1;
            end
        end
    end

`ifdef JTFRAME_SPI_LOADER_CHKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                   chksum <= '0;
        else if (st == StIdle && start) chksum <= '0;
        else if (src_take)            chksum <= chksum + {8'd0, src_data};
    end
`else
    assign chksum = '0;
`endif

endmodule
